// File: rtl/forward_select_unit_pkg.sv
// Shared types for the EX operand forwarding unit: select codes, FSM states,
// in-flight destination tracker entries and the per-source select helper.
package mips_fwd_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG   = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_IMM = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        HOLD    = 2'b10
    } fsm_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] dest;
    } trk_entry_t;

    function automatic logic writes_src(trk_entry_t e, logic [REG_ADDR_W-1:0] src);
        return e.valid && e.reg_write && (e.dest == src) && (src != ZERO_REG);
    endfunction

    // The EX entry becomes MEM on the same edge the consumer enters EX, so it wins over MEM.
    function automatic fwd_sel_t src_sel(logic used, logic [REG_ADDR_W-1:0] src,
                                         trk_entry_t ex_e, trk_entry_t mem_e);
        if (!used)                 return FWD_RF;
        if (writes_src(ex_e, src)) return FWD_MEM;
        if (writes_src(mem_e, src)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_select_unit_if.sv
// ID-side bundle: decoded source/destination info in, EX mux selects and stall out.
interface forward_select_unit_if;
    import mips_fwd_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic                  id_use_imm;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  flush;
    logic                  mem_busy;
    fwd_sel_t              fwd_sel_a;
    fwd_sel_t              fwd_sel_b;
    logic                  stall_if_id;
    logic                  ex_bubble;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_use_imm,
               id_reg_write, id_is_load, id_dest, flush, mem_busy,
        input  fwd_sel_a, fwd_sel_b, stall_if_id, ex_bubble
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_use_imm,
               id_reg_write, id_is_load, id_dest, flush, mem_busy,
        output fwd_sel_a, fwd_sel_b, stall_if_id, ex_bubble
    );

endinterface

// File: rtl/forward_select_unit_tracker.sv
// Three-entry shift register of in-flight destinations (EX, MEM, WB).
// The caller supplies either the ID instruction or an all-zero bubble as ins_i.
module pipe_dest_tracker
    import mips_fwd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  trk_entry_t ins_i,
    output trk_entry_t ex_o,
    output trk_entry_t mem_o,
    output trk_entry_t wb_o
);

    trk_entry_t [2:0] stage_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q <= {stage_q[1], stage_q[0], ins_i};
        end
    end

    assign ex_o  = stage_q[0];
    assign mem_o = stage_q[1];
    assign wb_o  = stage_q[2];

endmodule

// File: rtl/forward_select_unit.sv
// Forwarding select / load-use stall unit between ID and EX. Selects are
// registered as the ID instruction advances; bubbles carry 00 selects.
module forward_select_unit
    import mips_fwd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    forward_select_unit_if.slave bus
);

    fsm_state_t state_q, state_d, ret_q, ret_d, eff_state;
    fwd_sel_t   sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic       bubble_q, bubble_d;
    trk_entry_t ex_e, mem_e, wb_e, ins;
    logic       freeze, load_use, adv, ld_hit;
    logic       unused_wb;

    pipe_dest_tracker u_trk (
        .clk   (clk),
        .reset (reset),
        .en_i  (!freeze),
        .ins_i (ins),
        .ex_o  (ex_e),
        .mem_o (mem_e),
        .wb_o  (wb_e)
    );

    // WB entry is tracked for completeness but no select code reads it.
    assign unused_wb = ^wb_e;

    // While leaving HOLD the unit behaves as the state HOLD was entered from.
    assign freeze    = bus.mem_busy;
    assign eff_state = (state_q == HOLD) ? ret_q : state_q;

    assign ld_hit = ex_e.valid && ex_e.is_load && (ex_e.dest != ZERO_REG) &&
                    ((bus.id_uses_rs && (ex_e.dest == bus.id_rs)) ||
                     (bus.id_uses_rt && (ex_e.dest == bus.id_rt)));

    assign load_use = bus.id_valid && !bus.flush && ld_hit;
    assign adv      = bus.id_valid && !bus.flush && !load_use;

    always_comb begin
        ins = '0;
        if (adv) begin
            ins.valid     = 1'b1;
            ins.reg_write = bus.id_reg_write;
            ins.is_load   = bus.id_is_load;
            ins.dest      = bus.id_dest;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        sel_a_d  = sel_a_q;
        sel_b_d  = sel_b_q;
        bubble_d = bubble_q;
        if (freeze) begin
            state_d = HOLD;
            ret_d   = eff_state;
        end else begin
            bubble_d = !adv;
            sel_a_d  = adv ? src_sel(bus.id_uses_rs, bus.id_rs, ex_e, mem_e) : FWD_RF;
            if (!adv)                sel_b_d = FWD_RF;
            else if (bus.id_use_imm) sel_b_d = FWD_IMM;
            else                     sel_b_d = src_sel(bus.id_uses_rt, bus.id_rt, ex_e, mem_e);
            case (eff_state)
                RUN:     state_d = load_use ? LDSTALL : RUN;
                LDSTALL: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            ret_q    <= RUN;
            sel_a_q  <= FWD_RF;
            sel_b_q  <= FWD_RF;
            bubble_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.fwd_sel_a   = sel_a_q;
    assign bus.fwd_sel_b   = sel_b_q;
    assign bus.ex_bubble   = bubble_q;
    assign bus.stall_if_id = freeze || load_use;

endmodule
